// File: rtl/runner_sprite_ctrl.sv
// Runner sprite controller: jump/gravity physics, run animation and the packed sprite descriptor.
// Optional feature: define RUNNER_DOUBLE_JUMP_EN to allow one extra jump per airborne period.
module runner_sprite_ctrl #(
    parameter int GROUND_Y   = 400,
    parameter int MIN_Y      = 32,
    parameter int MAX_Y      = 480,
    parameter int X_BASE     = 80,
    parameter int TICK_DIV   = 100000,
    parameter int JUMP_V0    = 8,
    parameter int GRAVITY    = 1,
    parameter int VMAX       = 15,
    parameter int ANIM_DIV   = 200000,
    parameter int RUN_FRAMES = 5,
    parameter int COOLDOWN   = 500000,
    parameter int SPRITE_ID  = 0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        jump_req,
    input  logic        game_over,
    input  logic        on_ground,
    input  logic        dis_enable,
    input  logic [9:0]  x_shift,
    output logic [9:0]  pos_x,
    output logic [9:0]  pos_y,
    output logic [5:0]  vel,
    output logic [1:0]  state,
    output logic        fell,
    output logic [31:0] dina,
    output logic [2:0]  addr
);

    localparam int TICK_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int ANIM_W = (ANIM_DIV > 1) ? $clog2(ANIM_DIV) : 1;
    localparam int COOL_W = (COOLDOWN > 0) ? $clog2(COOLDOWN + 1) : 1;

    typedef enum logic [1:0] {
        ST_RUN  = 2'd0,
        ST_RISE = 2'd1,
        ST_FALL = 2'd2,
        ST_OUT  = 2'd3
    } state_e;

    state_e              state_q, state_d;
    logic [9:0]          pos_x_q;
    logic [9:0]          pos_y_q, pos_y_d;
    logic [5:0]          vel_q, vel_d;
    logic                fell_q, fell_d;
    logic [COOL_W-1:0]   cool_q, cool_d;
    logic [TICK_W-1:0]   tick_q, tick_d;
    logic [ANIM_W-1:0]   anim_q, anim_d;
    logic [2:0]          frame_q, frame_d;
    logic [2:0]          rom_row_q, rom_row_d;
    logic [2:0]          rom_col_q, rom_col_d;
    logic                jump_prev_q;
    logic [31:0]         dina_q, dina_d;

    logic                jump_edge, tick_hit, ground_jump, air_jump;
    logic signed [10:0]  rise_diff;
    logic [9:0]          rise_y;
    logic [5:0]          rise_v;
    logic [6:0]          fall_sum;
    logic [5:0]          fall_v;
    logic [10:0]         fall_y11;
    logic [9:0]          fall_y;
    logic                landing;

    assign jump_edge   = jump_req & ~jump_prev_q;
    assign tick_hit    = (tick_q == TICK_W'(TICK_DIV - 1));
    assign ground_jump = jump_edge && (state_q == ST_RUN) && (cool_q == '0);

`ifdef RUNNER_DOUBLE_JUMP_EN
    logic air_used_q, air_used_d;
    assign air_jump = jump_edge && ((state_q == ST_RISE) || (state_q == ST_FALL)) && !air_used_q;
`else
    assign air_jump = 1'b0;
`endif

    // Position math is widened to 11 bits so MIN_Y/MAX_Y clamping never sees a wrapped value.
    assign rise_diff = $signed({1'b0, pos_y_q}) - $signed({5'b0, vel_q});
    assign rise_y    = (rise_diff < $signed(11'(MIN_Y))) ? 10'(MIN_Y) : rise_diff[9:0];
    assign rise_v    = (vel_q > 6'(GRAVITY)) ? vel_q - 6'(GRAVITY) : 6'd0;
    assign fall_sum  = {1'b0, vel_q} + 7'(GRAVITY);
    assign fall_v    = (fall_sum > 7'(VMAX)) ? 6'(VMAX) : fall_sum[5:0];
    assign fall_y11  = {1'b0, pos_y_q} + {5'b0, fall_v};
    assign fall_y    = (fall_y11 >= 11'(MAX_Y)) ? 10'(MAX_Y) : fall_y11[9:0];
    assign landing   = on_ground && (pos_y_q <= 10'(GROUND_Y)) && (fall_y11 >= 11'(GROUND_Y));

    always_comb begin
        // NOTE: every next-state signal takes its hold value first, so no branch can infer a latch.
        state_d  = state_q;
        pos_y_d  = pos_y_q;
        vel_d    = vel_q;
        cool_d   = cool_q;
        tick_d   = tick_q;
        anim_d   = anim_q;
        frame_d  = frame_q;
`ifdef RUNNER_DOUBLE_JUMP_EN
        air_used_d = air_used_q;
`endif

        if (!game_over) begin
            tick_d = tick_hit ? '0 : tick_q + TICK_W'(1);
            if (cool_q != '0) cool_d = cool_q - COOL_W'(1);

            if (state_q == ST_RUN) begin
                if (anim_q == ANIM_W'(ANIM_DIV - 1)) begin
                    anim_d  = '0;
                    frame_d = (frame_q == 3'(RUN_FRAMES - 1)) ? 3'd0 : frame_q + 3'd1;
                end else begin
                    anim_d = anim_q + ANIM_W'(1);
                end
            end

            // An accepted jump pre-empts this cycle's tick physics.
            if (ground_jump || air_jump) begin
                state_d = ST_RISE;
                vel_d   = 6'(JUMP_V0);
`ifdef RUNNER_DOUBLE_JUMP_EN
                if (air_jump) air_used_d = 1'b1;
`endif
            end else if (tick_hit) begin
                case (state_q)
                    ST_RUN: begin
                        if (!on_ground) begin
                            state_d = ST_FALL;
                            vel_d   = 6'd0;
                        end
                    end
                    ST_RISE: begin
                        pos_y_d = rise_y;
                        vel_d   = rise_v;
                        if (rise_v == 6'd0) state_d = ST_FALL;
                    end
                    ST_FALL: begin
                        if (landing) begin
                            pos_y_d = 10'(GROUND_Y);
                            vel_d   = 6'd0;
                            state_d = ST_RUN;
                            cool_d  = COOL_W'(COOLDOWN);
`ifdef RUNNER_DOUBLE_JUMP_EN
                            air_used_d = 1'b0;
`endif
                        end else begin
                            pos_y_d = fall_y;
                            vel_d   = fall_v;
                            if (fall_y == 10'(MAX_Y)) begin
                                state_d = ST_OUT;
                                vel_d   = 6'd0;
                            end
                        end
                    end
                    default: vel_d = 6'd0;
                endcase
            end
        end

        fell_d = (state_d == ST_OUT);

        rom_row_d = 3'd0;
        rom_col_d = frame_d;
        if (game_over) begin
            rom_row_d = 3'd1;
            rom_col_d = 3'd0;
        end else if (state_d == ST_RISE) begin
            rom_row_d = 3'd2;
            rom_col_d = 3'd0;
        end else if (state_d != ST_RUN) begin
            rom_row_d = 3'd2;
            rom_col_d = 3'd1;
        end

        dina_d = {dis_enable, 4'b0, 1'b0, pos_x_q, pos_y_q, rom_row_q, rom_col_q};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_RUN;
            pos_x_q     <= 10'(X_BASE);
            pos_y_q     <= 10'(GROUND_Y);
            vel_q       <= 6'd0;
            fell_q      <= 1'b0;
            cool_q      <= '0;
            tick_q      <= '0;
            anim_q      <= '0;
            frame_q     <= 3'd0;
            rom_row_q   <= 3'd0;
            rom_col_q   <= 3'd0;
            jump_prev_q <= 1'b0;
            dina_q      <= {1'b0, 5'b0, 10'(X_BASE), 10'(GROUND_Y), 6'b0};
`ifdef RUNNER_DOUBLE_JUMP_EN
            air_used_q  <= 1'b0;
`endif
        end else begin
            // NOTE: non-blocking assignments keep every register reading last cycle's values.
            state_q     <= state_d;
            pos_x_q     <= 10'(X_BASE) + x_shift;
            pos_y_q     <= pos_y_d;
            vel_q       <= vel_d;
            fell_q      <= fell_d;
            cool_q      <= cool_d;
            tick_q      <= tick_d;
            anim_q      <= anim_d;
            frame_q     <= frame_d;
            rom_row_q   <= rom_row_d;
            rom_col_q   <= rom_col_d;
            jump_prev_q <= jump_req;
            dina_q      <= dina_d;
`ifdef RUNNER_DOUBLE_JUMP_EN
            air_used_q  <= air_used_d;
`endif
        end
    end

    assign pos_x = pos_x_q;
    assign pos_y = pos_y_q;
    assign vel   = vel_q;
    assign state = state_q;
    assign fell  = fell_q;
    assign dina  = dina_q;
    assign addr  = 3'(SPRITE_ID);

endmodule

// File: tb/tb_runner_sprite_ctrl.sv
// Self-checking bench for runner_sprite_ctrl: vector table, directed corner sequences and
// randomized stimulus compared every cycle against an integer reference model.
module tb_runner_sprite_ctrl;

    localparam int GROUND_Y = 400, MIN_Y = 32, MAX_Y = 480, X_BASE = 80;
    localparam int TICK_DIV = 4, JUMP_V0 = 4, GRAVITY = 1, VMAX = 15;
    localparam int ANIM_DIV = 8, RUN_FRAMES = 5, COOLDOWN = 20, SPRITE_ID = 5;
`ifdef RUNNER_DOUBLE_JUMP_EN
    localparam bit DOUBLE_JUMP = 1'b1;
`else
    localparam bit DOUBLE_JUMP = 1'b0;
`endif
    localparam int S_RUN = 0, S_RISE = 1, S_FALL = 2, S_OUT = 3;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        jump_req = 1'b0;
    logic        game_over = 1'b0;
    logic        on_ground = 1'b1;
    logic        dis_enable = 1'b1;
    logic [9:0]  x_shift = '0;
    logic [9:0]  pos_x, pos_y;
    logic [5:0]  vel;
    logic [1:0]  state;
    logic        fell;
    logic [31:0] dina;
    logic [2:0]  addr;

    runner_sprite_ctrl #(
        .GROUND_Y(GROUND_Y), .MIN_Y(MIN_Y), .MAX_Y(MAX_Y), .X_BASE(X_BASE),
        .TICK_DIV(TICK_DIV), .JUMP_V0(JUMP_V0), .GRAVITY(GRAVITY), .VMAX(VMAX),
        .ANIM_DIV(ANIM_DIV), .RUN_FRAMES(RUN_FRAMES), .COOLDOWN(COOLDOWN), .SPRITE_ID(SPRITE_ID)
    ) dut (
        .clk(clk), .reset(reset), .jump_req(jump_req), .game_over(game_over),
        .on_ground(on_ground), .dis_enable(dis_enable), .x_shift(x_shift),
        .pos_x(pos_x), .pos_y(pos_y), .vel(vel), .state(state), .fell(fell),
        .dina(dina), .addr(addr)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;

    // Reference model state, kept as plain integers.
    int m_y, m_posx, m_vel, m_st, m_cool, m_tick, m_anim, m_frame, m_row, m_col;
    bit m_prev, m_air;
    logic [31:0] m_dina;

    typedef struct {
        logic jr, og, go;
        int   xs, cycles, st, y, v, fl, px, chk_spr, spr;
    } vec_t;
    vec_t vecs[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    task automatic model_step();
        bit edge_seen, tick_now, ground_ok, air_ok;
        int v, y;
        if (reset) begin
            m_y = GROUND_Y; m_posx = X_BASE; m_vel = 0; m_st = S_RUN; m_cool = 0;
            m_tick = 0; m_anim = 0; m_frame = 0; m_prev = 0; m_air = 0; m_row = 0; m_col = 0;
            m_dina = {1'b0, 5'b0, 10'(X_BASE), 10'(GROUND_Y), 6'b0};
        end else begin
            m_dina = {dis_enable, 5'b0, 10'(m_posx), 10'(m_y), 3'(m_row), 3'(m_col)};
            m_posx = (X_BASE + int'(x_shift)) % 1024;
            edge_seen = jump_req && !m_prev;
            m_prev = jump_req;
            if (!game_over) begin
                tick_now  = (m_tick == TICK_DIV - 1);
                m_tick    = (m_tick + 1) % TICK_DIV;
                ground_ok = edge_seen && m_st == S_RUN && m_cool == 0;
                air_ok    = DOUBLE_JUMP && edge_seen && (m_st == S_RISE || m_st == S_FALL) && !m_air;
                if (m_cool > 0) m_cool--;
                if (m_st == S_RUN) begin
                    m_anim++;
                    if (m_anim == ANIM_DIV) begin
                        m_anim = 0;
                        m_frame = (m_frame + 1) % RUN_FRAMES;
                    end
                end
                if (ground_ok || air_ok) begin
                    m_st = S_RISE;
                    m_vel = JUMP_V0;
                    if (air_ok) m_air = 1;
                end else if (tick_now) begin
                    if (m_st == S_RUN && !on_ground) begin
                        m_st = S_FALL; m_vel = 0;
                    end else if (m_st == S_RISE) begin
                        m_y = (m_y - m_vel < MIN_Y) ? MIN_Y : m_y - m_vel;
                        m_vel = (m_vel - GRAVITY < 0) ? 0 : m_vel - GRAVITY;
                        if (m_vel == 0) m_st = S_FALL;
                    end else if (m_st == S_FALL) begin
                        v = (m_vel + GRAVITY > VMAX) ? VMAX : m_vel + GRAVITY;
                        y = m_y + v;
                        if (on_ground && m_y <= GROUND_Y && y >= GROUND_Y) begin
                            m_y = GROUND_Y; m_vel = 0; m_st = S_RUN; m_cool = COOLDOWN; m_air = 0;
                        end else begin
                            m_y = (y > MAX_Y) ? MAX_Y : y;
                            m_vel = v;
                            if (m_y == MAX_Y) begin
                                m_st = S_OUT; m_vel = 0;
                            end
                        end
                    end else if (m_st == S_OUT) begin
                        m_vel = 0;
                    end
                end
            end
            if (game_over) begin
                m_row = 1; m_col = 0;
            end else if (m_st == S_RUN) begin
                m_row = 0; m_col = m_frame;
            end else if (m_st == S_RISE) begin
                m_row = 2; m_col = 0;
            end else begin
                m_row = 2; m_col = 1;
            end
        end
    endtask

    task automatic step();
        logic [63:0] exp_snap;
        @(posedge clk);
        model_step();
        #1;
        exp_snap = {10'(m_posx), 10'(m_y), 6'(m_vel), 2'(m_st), (m_st == S_OUT), m_dina, 3'(SPRITE_ID)};
        check("model", {pos_x, pos_y, vel, state, fell, dina, addr}, exp_snap);
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic do_reset();
        reset = 1'b1; jump_req = 1'b0; on_ground = 1'b1; game_over = 1'b0;
        dis_enable = 1'b1; x_shift = '0;
        steps(3);
        reset = 1'b0;
    endtask

    task automatic expect_dyn(input string tag, input int st, input int y, input int v);
        check({tag, "_state"}, 64'(state), 64'(st));
        check({tag, "_pos_y"}, 64'(pos_y), 64'(y));
        check({tag, "_vel"}, 64'(vel), 64'(v));
    endtask

    task automatic add(input logic jr, input logic og, input logic go, input int xs, input int n,
                       input int st, input int y, input int v, input int fl, input int px,
                       input int chk, input int spr);
        vec_t e;
        e.jr = jr; e.og = og; e.go = go; e.xs = xs; e.cycles = n; e.st = st; e.y = y; e.v = v;
        e.fl = fl; e.px = px; e.chk_spr = chk; e.spr = spr;
        vecs.push_back(e);
    endtask

    initial begin
        int exp_fall[3] = '{401, 403, 406};
        int exp_col[6]  = '{0, 1, 2, 3, 4, 0};
        int go_left, og_mode;

        // Full jump, cooldown rejection, game_over freeze, gap fall to OUT.
        add(0,1,0,   0, 1, S_RUN, 400, 0, 0, 80, 1,  0);
        add(1,1,0,   0, 1, S_RISE,400, 4, 0, 80, 1,  0);
        add(1,1,0,   0, 2, S_RISE,396, 3, 0, 80, 1, 16);
        add(1,1,0,   0, 4, S_RISE,393, 2, 0, 80, 1, 16);
        add(1,1,0,   0, 4, S_RISE,391, 1, 0, 80, 1, 16);
        add(1,1,0,   0, 4, S_FALL,390, 0, 0, 80, 1, 16);
        add(1,1,0,   0, 4, S_FALL,391, 1, 0, 80, 1, 17);
        add(1,1,0,   0, 4, S_FALL,393, 2, 0, 80, 1, 17);
        add(1,1,0,   0, 4, S_FALL,396, 3, 0, 80, 1, 17);
        add(1,1,0,   0, 4, S_RUN, 400, 0, 0, 80, 1, 17);
        add(0,1,0,   0, 4, S_RUN, 400, 0, 0, 80, 0,  0);
        add(1,1,0,   0, 1, S_RUN, 400, 0, 0, 80, 0,  0);
        add(1,1,0,   0,18, S_RUN, 400, 0, 0, 80, 0,  0);
        add(0,1,0,   0, 1, S_RUN, 400, 0, 0, 80, 0,  0);
        add(1,1,0,   0, 1, S_RISE,400, 4, 0, 80, 0,  0);
        add(1,1,0,   0, 3, S_RISE,396, 3, 0, 80, 1, 16);
        add(1,1,1,  10, 8, S_RISE,396, 3, 0, 90, 1,  8);
        add(1,1,0,1023, 3, S_RISE,396, 3, 0, 79, 1, 16);
        add(1,1,0,1023, 1, S_RISE,393, 2, 0, 79, 1, 16);
        add(1,1,0,   0,12, S_FALL,391, 1, 0, 80, 1, 17);
        add(1,0,0,   0,12, S_FALL,400, 4, 0, 80, 1, 17);
        add(1,0,0,   0, 4, S_FALL,405, 5, 0, 80, 1, 17);
        add(1,0,0,   0,28, S_FALL,468,12, 0, 80, 1, 17);
        add(1,0,0,   0, 4, S_OUT, 480, 0, 1, 80, 1, 17);
        add(0,1,0,   0, 1, S_OUT, 480, 0, 1, 80, 1, 17);
        add(1,1,0,   0, 4, S_OUT, 480, 0, 1, 80, 1, 17);

        do_reset();
        expect_dyn("reset", S_RUN, GROUND_Y, 0);
        check("reset_fell", 64'(fell), 64'(0));
        check("reset_pos_x", 64'(pos_x), 64'(X_BASE));
        check("reset_dina", 64'(dina), 64'({1'b0, 5'b0, 10'(X_BASE), 10'(GROUND_Y), 6'b0}));
        check("addr", 64'(addr), 64'(SPRITE_ID));

        foreach (vecs[i]) begin
            jump_req = vecs[i].jr; on_ground = vecs[i].og; game_over = vecs[i].go;
            x_shift = 10'(vecs[i].xs);
            steps(vecs[i].cycles);
            expect_dyn($sformatf("vec%0d", i), vecs[i].st, vecs[i].y, vecs[i].v);
            check($sformatf("vec%0d_fell", i), 64'(fell), 64'(vecs[i].fl));
            check($sformatf("vec%0d_pos_x", i), 64'(pos_x), 64'(vecs[i].px));
            if (vecs[i].chk_spr != 0)
                check($sformatf("vec%0d_sprite", i), 64'(dina[5:0]), 64'(vecs[i].spr));
        end

        // Falling off the floor straight from RUN.
        do_reset();
        on_ground = 1'b0;
        steps(4);
        expect_dyn("gap_enter", S_FALL, 400, 0);
        for (int k = 0; k < 3; k++) begin
            steps(4);
            expect_dyn($sformatf("gap_tick%0d", k), S_FALL, exp_fall[k], k + 1);
        end

        // Reset asserted mid-jump.
        do_reset();
        jump_req = 1'b1;
        steps(5);
        check("midjump_pos_y", 64'(pos_y), 64'(396));
        reset = 1'b1; x_shift = 10'd7;
        steps(1);
        expect_dyn("midjump_reset", S_RUN, GROUND_Y, 0);
        check("midjump_reset_fell", 64'(fell), 64'(0));
        check("midjump_reset_pos_x", 64'(pos_x), 64'(X_BASE));
        check("midjump_reset_dina", 64'(dina), 64'({1'b0, 5'b0, 10'(X_BASE), 10'(GROUND_Y), 6'b0}));

        // Idle run animation.
        do_reset();
        steps(1);
        for (int k = 0; k < 6; k++) begin
            if (k > 0) steps(8);
            check($sformatf("anim_col%0d", k), 64'(dina[5:0]), 64'(exp_col[k]));
        end

        // Edge on the first FALL tick: air jump when enabled, ignored otherwise.
        do_reset();
        jump_req = 1'b1;
        steps(1);
        steps(15);
        expect_dyn("dj_apex", S_FALL, 390, 0);
        jump_req = 1'b0;
        steps(3);
        jump_req = 1'b1;
        steps(1);
        if (DOUBLE_JUMP) expect_dyn("dj_accept", S_RISE, 390, 4);
        else             expect_dyn("dj_accept", S_FALL, 391, 1);
        steps(4);
        if (DOUBLE_JUMP) expect_dyn("dj_rise", S_RISE, 386, 3);
        else             expect_dyn("dj_rise", S_FALL, 393, 2);
        jump_req = 1'b0;
        steps(1);
        jump_req = 1'b1;
        steps(3);
        if (DOUBLE_JUMP) expect_dyn("dj_third", S_RISE, 383, 2);
        else             expect_dyn("dj_third", S_FALL, 396, 3);

        // Randomized traffic against the model.
        do_reset();
        go_left = 0;
        og_mode = 0;
        for (int c = 0; c < 4000; c++) begin
            if (c % 64 == 0) og_mode = int'($urandom_range(0, 2));
            case (og_mode)
                0:       on_ground = 1'b1;
                1:       on_ground = ($urandom_range(0, 7) != 0);
                default: on_ground = 1'b0;
            endcase
            if (go_left > 0) begin
                game_over = 1'b1;
                go_left--;
            end else begin
                game_over = 1'b0;
                if ($urandom_range(0, 59) == 0) go_left = int'($urandom_range(1, 12));
            end
            if ($urandom_range(0, 2) == 0) jump_req = ~jump_req;
            dis_enable = 1'($urandom_range(0, 1));
            x_shift = 10'($urandom_range(0, 1023));
            reset = ($urandom_range(0, 399) == 0);
            step();
        end
        reset = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
